// File: rtl/div_pkg.sv
// Shared types and helpers for the multi-channel sequential divider.
package div_pkg;
  typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

  localparam int MAX_W = 64;

  // Iteration-counter width for a given operand width.
  function automatic int cnt_w(input int width);
    return $clog2(width + 1);
  endfunction

  // Two's-complement conditional negate; callers zero-extend in and truncate out.
  function automatic logic [MAX_W-1:0] cond_neg(input logic [MAX_W-1:0] x, input logic neg);
    return neg ? (~x + MAX_W'(1)) : x;
  endfunction
endpackage

// File: rtl/div_restore_step.sv
// One restoring-division iteration: shift {rem, quo} left, trial-subtract divisor.
module div_restore_step #(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH:0]   rem,
  input  logic [WIDTH-1:0] quo,
  input  logic [WIDTH-1:0] dvs,
  output logic [WIDTH:0]   rem_nxt,
  output logic [WIDTH-1:0] quo_nxt
);
  logic [WIDTH+1:0] sh, diff;
  logic             neg;

  assign sh      = {rem, quo[WIDTH-1]};
  assign diff    = sh - {2'b00, dvs};
  assign neg     = diff[WIDTH+1];
  assign rem_nxt = neg ? sh[WIDTH:0] : diff[WIDTH:0];
  assign quo_nxt = {quo[WIDTH-2:0], ~neg};
endmodule

// File: rtl/seq_divider_mc.sv
// Multi-channel restoring divider, one quotient bit per clock, signed/unsigned,
// with divide-by-zero and MIN/-1 overflow reporting.
module seq_divider_mc
  import div_pkg::*;
#(
  parameter int WIDTH    = 16,
  parameter int CHANNELS = 2,
  parameter int SEL_W    = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      start,
  input  logic                      signed_mode,
  input  logic [SEL_W-1:0]          sel,
  input  logic [CHANNELS*WIDTH-1:0] dividend_bus,
  input  logic [CHANNELS*WIDTH-1:0] divisor_bus,
  output logic [WIDTH-1:0]          quotient,
  output logic [WIDTH-1:0]          remainder,
  output logic                      busy,
  output logic                      done,
  output logic                      div_by_zero,
  output logic                      overflow
);
  localparam int              CW  = cnt_w(WIDTH);
  localparam logic [WIDTH-1:0] MIN = {1'b1, {(WIDTH-1){1'b0}}};

  state_t           state;
  logic [CW-1:0]    cnt;
  logic [WIDTH:0]   rem_r, rem_n;
  logic [WIDTH-1:0] quo_r, quo_n, dvs_r;
  logic             neg_q, neg_r, dbz_r, ovf_r;

  int               ch;
  logic [WIDTH-1:0] dvd_sel, dvs_sel, dvd_mag, dvs_mag, q_fix, r_fix;
  logic             dvd_neg, dvs_neg, dvs_zero;

  always_comb begin
    ch       = (int'(sel) < CHANNELS) ? int'(sel) : 0;
    dvd_sel  = dividend_bus[ch*WIDTH +: WIDTH];
    dvs_sel  = divisor_bus[ch*WIDTH +: WIDTH];
    dvd_neg  = signed_mode & dvd_sel[WIDTH-1];
    dvs_neg  = signed_mode & dvs_sel[WIDTH-1];
    dvs_zero = (dvs_sel == '0);
    dvd_mag  = WIDTH'(cond_neg(MAX_W'(dvd_sel), dvd_neg));
    dvs_mag  = WIDTH'(cond_neg(MAX_W'(dvs_sel), dvs_neg));
    // MIN/-1 needs no special casing: the 0x8..0 magnitude wraps back to MIN.
    q_fix    = WIDTH'(cond_neg(MAX_W'(quo_r), neg_q));
    r_fix    = WIDTH'(cond_neg(MAX_W'(rem_r[WIDTH-1:0]), neg_r));
  end

  div_restore_step #(.WIDTH(WIDTH)) u_step (
    .rem     (rem_r),
    .quo     (quo_r),
    .dvs     (dvs_r),
    .rem_nxt (rem_n),
    .quo_nxt (quo_n)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      cnt         <= '0;
      rem_r       <= '0;
      quo_r       <= '0;
      dvs_r       <= '0;
      neg_q       <= 1'b0;
      neg_r       <= 1'b0;
      dbz_r       <= 1'b0;
      ovf_r       <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      div_by_zero <= 1'b0;
      overflow    <= 1'b0;
    end else begin
      case (state)
        IDLE: if (start) begin
          // On divide-by-zero the raw dividend rides in quo_r to become the remainder.
          quo_r       <= dvs_zero ? dvd_sel : dvd_mag;
          dvs_r       <= dvs_mag;
          rem_r       <= '0;
          cnt         <= '0;
          neg_q       <= dvd_neg ^ dvs_neg;
          neg_r       <= dvd_neg;
          dbz_r       <= dvs_zero;
          ovf_r       <= signed_mode && (dvd_sel == MIN) && (&dvs_sel);
          done        <= 1'b0;
          div_by_zero <= 1'b0;
          overflow    <= 1'b0;
          busy        <= 1'b1;
          state       <= dvs_zero ? FIX : CALC;
        end
        CALC: begin
          rem_r <= rem_n;
          quo_r <= quo_n;
          cnt   <= cnt + CW'(1);
          if (cnt == CW'(WIDTH - 1)) state <= FIX;
        end
        FIX: begin
          quotient    <= dbz_r ? '1 : q_fix;
          remainder   <= dbz_r ? quo_r : r_fix;
          div_by_zero <= dbz_r;
          overflow    <= ovf_r;
          done        <= 1'b1;
          busy        <= 1'b0;
          state       <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_seq_divider_mc.sv
// Bench for seq_divider_mc: directed table and corner sequences on a 16-bit/2-channel
// instance, randomized model comparison on an 8-bit/3-channel instance.
module tb_seq_divider_mc;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic        st16, sm16;
  logic [0:0]  sel16;
  logic [31:0] dvd16, dvs16;
  logic [15:0] q16, r16;
  logic        busy16, done16, dbz16, ovf16;

  logic        st8, sm8;
  logic [1:0]  sel8;
  logic [23:0] dvd8, dvs8;
  logic [7:0]  q8, r8;
  logic        busy8, done8, dbz8, ovf8;

  seq_divider_mc #(.WIDTH(16), .CHANNELS(2)) u_dut16 (
    .clk(clk), .reset(reset), .start(st16), .signed_mode(sm16), .sel(sel16),
    .dividend_bus(dvd16), .divisor_bus(dvs16), .quotient(q16), .remainder(r16),
    .busy(busy16), .done(done16), .div_by_zero(dbz16), .overflow(ovf16));

  seq_divider_mc #(.WIDTH(8), .CHANNELS(3)) u_dut8 (
    .clk(clk), .reset(reset), .start(st8), .signed_mode(sm8), .sel(sel8),
    .dividend_bus(dvd8), .divisor_bus(dvs8), .quotient(q8), .remainder(r8),
    .busy(busy8), .done(done8), .div_by_zero(dbz8), .overflow(ovf8));

  int          cur;
  logic [15:0] oq, orr;
  logic        ob, od, oz, oo;
  always_comb begin
    oq  = (cur == 0) ? q16 : {8'h00, q8};
    orr = (cur == 0) ? r16 : {8'h00, r8};
    ob  = (cur == 0) ? busy16 : busy8;
    od  = (cur == 0) ? done16 : done8;
    oz  = (cur == 0) ? dbz16  : dbz8;
    oo  = (cur == 0) ? ovf16  : ovf8;
  end

  typedef struct {logic [15:0] q, r; logic dbz, ovf; int lat;} exp_t;
  typedef struct {logic sm; int sel; logic [15:0] a, b, q, r; logic dbz, ovf;} vec_t;

  exp_t sb[$];
  vec_t tbl[11];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string nm, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic exp_t model(input int w, input logic sm, input logic [15:0] a, input logic [15:0] b);
    exp_t   e;
    longint mask, sa, sb_, qq, rr;
    mask = (longint'(1) << w) - 1;
    e = '{q: 16'h0, r: 16'h0, dbz: 1'b0, ovf: 1'b0, lat: (b == 0) ? 1 : w + 1};
    if (b == 0) begin
      e.q = 16'(mask); e.r = a; e.dbz = 1'b1;
    end else begin
      if (sm) begin
        sa  = a[w-1] ? longint'(a) - (longint'(1) << w) : longint'(a);
        sb_ = b[w-1] ? longint'(b) - (longint'(1) << w) : longint'(b);
      end else begin
        sa = longint'(a); sb_ = longint'(b);
      end
      if (sm && sa == -(longint'(1) << (w - 1)) && sb_ == -1) begin
        qq = sa; rr = 0; e.ovf = 1'b1;
      end else begin
        qq = sa / sb_; rr = sa % sb_;
      end
      e.q = 16'(qq & mask); e.r = 16'(rr & mask);
    end
    return e;
  endfunction

  task automatic set_start(input int which, input logic v);
    if (which == 0) st16 = v; else st8 = v;
  endtask

  task automatic scramble(input int which);
    if (which == 0) begin
      dvd16 = $urandom; dvs16 = $urandom; sm16 = 1'($urandom); sel16 = 1'($urandom);
    end else begin
      dvd8 = 24'($urandom); dvs8 = 24'($urandom); sm8 = 1'($urandom); sel8 = 2'($urandom);
    end
  endtask

  task automatic load(input int which, input logic sm, input int sel, input logic [15:0] a, input logic [15:0] b);
    int eff;
    scramble(which);
    if (which == 0) begin
      eff = (sel < 2) ? sel : 0;
      dvd16[eff*16 +: 16] = a; dvs16[eff*16 +: 16] = b; sm16 = sm; sel16 = 1'(sel);
    end else begin
      eff = (sel < 3) ? sel : 0;
      dvd8[eff*8 +: 8] = a[7:0]; dvs8[eff*8 +: 8] = b[7:0]; sm8 = sm; sel8 = 2'(sel);
    end
  endtask

  // mode 1 re-pulses start and scrambles the buses in the middle of CALC.
  task automatic do_op(input string tag, input int which, input logic sm, input int sel,
                       input logic [15:0] a, input logic [15:0] b, input logic [15:0] eq,
                       input logic [15:0] er, input logic ez, input logic eo, input int mode);
    exp_t e;
    int   w, lat, bcnt;
    logic got;
    w = (which == 0) ? 16 : 8;
    sb.push_back('{q: eq, r: er, dbz: ez, ovf: eo, lat: (b == 0) ? 1 : w + 1});
    cur = which;
    load(which, sm, sel, a, b);
    set_start(which, 1'b1);
    @(posedge clk); #1;
    set_start(which, 1'b0);
    chk({tag, ".done_clr"}, od, 0);
    bcnt = ob ? 1 : 0; lat = 0; got = 1'b0;
    while (!got && lat < 40) begin
      @(posedge clk); #1; lat++;
      if (mode == 1 && lat == 3) begin set_start(which, 1'b1); scramble(which); end
      if (mode == 1 && lat == 6) set_start(which, 1'b0);
      if (od) got = 1'b1; else if (ob) bcnt++;
    end
    e = sb.pop_front();
    chk({tag, ".timeout"}, got, 1);
    if (got) begin
      chk({tag, ".q"}, oq, e.q);
      chk({tag, ".r"}, orr, e.r);
      chk({tag, ".dbz"}, oz, e.dbz);
      chk({tag, ".ovf"}, oo, e.ovf);
      chk({tag, ".lat"}, lat, e.lat);
      chk({tag, ".busy_cycles"}, bcnt, e.lat);
      chk({tag, ".busy_at_done"}, ob, 0);
    end
  endtask

  initial begin
    int   lat;
    logic seen;
    exp_t e;
    tbl[0]  = '{sm: 1'b0, sel: 1, a: 16'd1000, b: 16'd7,  q: 16'd142,  r: 16'd6,    dbz: 1'b0, ovf: 1'b0};
    tbl[1]  = '{sm: 1'b1, sel: 0, a: 16'hFF9C, b: 16'd7,  q: 16'hFFF2, r: 16'hFFFE, dbz: 1'b0, ovf: 1'b0};
    tbl[2]  = '{sm: 1'b1, sel: 0, a: 16'd100,  b: 16'hFFF9, q: 16'hFFF2, r: 16'h0002, dbz: 1'b0, ovf: 1'b0};
    tbl[3]  = '{sm: 1'b0, sel: 0, a: 16'h1234, b: 16'h0,  q: 16'hFFFF, r: 16'h1234, dbz: 1'b1, ovf: 1'b0};
    tbl[4]  = '{sm: 1'b1, sel: 1, a: 16'h8000, b: 16'hFFFF, q: 16'h8000, r: 16'h0,  dbz: 1'b0, ovf: 1'b1};
    tbl[5]  = '{sm: 1'b0, sel: 0, a: 16'hFFFF, b: 16'h1,  q: 16'hFFFF, r: 16'h0,    dbz: 1'b0, ovf: 1'b0};
    tbl[6]  = '{sm: 1'b1, sel: 1, a: 16'hFF9C, b: 16'hFFF9, q: 16'h000E, r: 16'hFFFE, dbz: 1'b0, ovf: 1'b0};
    tbl[7]  = '{sm: 1'b0, sel: 1, a: 16'd5,    b: 16'd9,  q: 16'h0,    r: 16'd5,    dbz: 1'b0, ovf: 1'b0};
    tbl[8]  = '{sm: 1'b1, sel: 0, a: 16'h8000, b: 16'h0,  q: 16'hFFFF, r: 16'h8000, dbz: 1'b1, ovf: 1'b0};
    tbl[9]  = '{sm: 1'b0, sel: 1, a: 16'hFFFF, b: 16'hFFFF, q: 16'h1,  r: 16'h0,    dbz: 1'b0, ovf: 1'b0};
    tbl[10] = '{sm: 1'b1, sel: 0, a: 16'd7,    b: 16'd2,  q: 16'd3,    r: 16'd1,    dbz: 1'b0, ovf: 1'b0};

    cur = 0; reset = 1'b1;
    st16 = 1'b0; sm16 = 1'b0; sel16 = '0; dvd16 = '0; dvs16 = '0;
    st8  = 1'b0; sm8  = 1'b0; sel8  = '0; dvd8  = '0; dvs8  = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst16.outs", {q16, r16, busy16, done16, dbz16, ovf16}, 0);
    chk("rst8.outs",  {q8, r8, busy8, done8, dbz8, ovf8}, 0);
    reset = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < 11; i++)
      do_op($sformatf("tbl%0d", i), 0, tbl[i].sm, tbl[i].sel, tbl[i].a, tbl[i].b,
            tbl[i].q, tbl[i].r, tbl[i].dbz, tbl[i].ovf, 0);

    do_op("disturb", 0, 1'b0, 1, 16'd1000, 16'd7, 16'd142, 16'd6, 1'b0, 1'b0, 1);

    // start held high across the done edge: taken on the following IDLE cycle.
    cur = 0; load(0, 1'b0, 1, 16'd1000, 16'd7); st16 = 1'b1;
    lat = 0; seen = 1'b0;
    while (!seen && lat < 40) begin @(posedge clk); #1; lat++; seen = done16; end
    chk("hold.done", seen, 1);
    chk("hold.q", q16, 16'd142);
    @(posedge clk); #1;
    chk("hold.reaccept", {busy16, done16}, 2'b10);
    st16 = 1'b0;
    lat = 0; seen = 1'b0;
    while (!seen && lat < 40) begin @(posedge clk); #1; lat++; seen = done16; end
    chk("hold.done2", seen, 1);
    chk("hold.r2", r16, 16'd6);

    // Reset sampled at edge A+5 aborts the division with no done.
    load(0, 1'b0, 0, 16'd500, 16'd3); st16 = 1'b1;
    @(posedge clk); #1; st16 = 1'b0;
    repeat (4) @(posedge clk);
    #1; reset = 1'b1;
    @(posedge clk); #1;
    chk("midrst.outs", {q16, r16, busy16, done16, dbz16, ovf16}, 0);
    reset = 1'b0; seen = 1'b0;
    repeat (25) begin @(posedge clk); #1; seen |= done16; end
    chk("midrst.no_done", seen, 0);
    do_op("after_rst", 0, 1'b0, 0, 16'd500, 16'd3, 16'd166, 16'd2, 1'b0, 1'b0, 0);

    do_op("w8.sel3", 1, 1'b0, 3, 16'd100, 16'd7, 16'd14, 16'd2, 1'b0, 1'b0, 0);
    for (int i = 0; i < 1000; i++) begin
      logic [15:0] a, b;
      logic        sm;
      int          sel, pick;
      sm   = 1'(i);
      a    = 16'($urandom_range(0, 255));
      pick = $urandom_range(0, 15);
      if (pick == 0)      b = 16'h0;
      else if (pick == 1) begin a = 16'h80; b = 16'hFF; end
      else                b = 16'($urandom_range(0, 255));
      sel = $urandom_range(0, 3);
      e = model(8, sm, a, b);
      do_op($sformatf("rnd%0d", i), 1, sm, sel, a, b, e.q, e.r, e.dbz, e.ovf, 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
